// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Owns the single write port of the integer register file. Merges in-order
// pipeline write-backs with out-of-order long-latency results (mult/div,
// FPU-to-int moves), which are buffered in a small FIFO. The pipe always
// wins. The FIFO drains whenever the pipe has nothing to write. A register
// scoreboard lets decode stall on registers that have a long-latency write
// in flight.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, a long-latency result goes straight to the output register
//   if it arrives while the FIFO is empty and the pipe is idle.
//
// Parameters
//   XLEN        data width
//   DEPTH       long-latency FIFO entries (power of two, >= 2)
//   STARVE_MAX  consecutive blocked cycles before wb_hold asserts (>= 1)
//
// Ports
//   clk, rst_b              clock (posedge), async active-low reset
//   p_valid/p_num/p_data    pipeline write-back (never back-pressured)
//   ll_valid/ll_ready/...   long-latency result handshake into the FIFO
//   q_rs/q_rt/q_rd          decode scoreboard queries
//   rs/rt/rd_pending        queried register has an in-flight ll write
//   wb_hold                 advisory request for an upstream write-back bubble
//   rd_we/rd_num/rd_data    registered register-file write port
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            p_valid,
    input  logic [4:0]      p_num,
    input  logic [XLEN-1:0] p_data,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [4:0]      ll_num,
    input  logic [XLEN-1:0] ll_data,
    input  logic [4:0]      q_rs,
    input  logic [4:0]      q_rt,
    input  logic [4:0]      q_rd,
    output logic            rs_pending,
    output logic            rt_pending,
    output logic            rd_pending,
    output logic            wb_hold,
    output logic            rd_we,
    output logic [4:0]      rd_num,
    output logic [XLEN-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    // FIFO storage and control
    logic [4:0]      r_fifo_num  [DEPTH];
    logic [XLEN-1:0] r_fifo_data [DEPTH];
    logic [DEPTH-1:0] r_fifo_vld;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    // Output and starvation state
    logic            r_rd_we;
    logic [4:0]      r_rd_num;
    logic [XLEN-1:0] r_rd_data;
    logic [CW-1:0]   r_starve_cnt;
    logic            r_wb_hold;

    // Decode of this cycle's activity
    logic w_full;
    logic w_empty;
    logic w_xfer;
    logic w_pipe;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_rd_hit;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Readiness is forced low during reset so nothing is taken while the
    // FIFO is being discarded. A slot freed by a pop only reopens next cycle.
    assign ll_ready = rst_b && !w_full;
    assign w_xfer   = ll_valid && ll_ready;

    // A pipe write to r0 is no write at all, letting the FIFO drain.
    assign w_pipe = p_valid && (p_num != 5'd0);

`ifdef WB_BYPASS_EN
    assign w_bypass = w_xfer && (ll_num != 5'd0) && !w_pipe && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // Results for r0 complete the handshake but are silently dropped.
    assign w_push = w_xfer && (ll_num != 5'd0) && !w_bypass;
    assign w_pop  = !w_pipe && !w_empty;

    // Scoreboard: match against every live FIFO entry.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        w_rd_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fifo_vld[i] && (r_fifo_num[i] == q_rs)) w_rs_hit = 1'b1;
            if (r_fifo_vld[i] && (r_fifo_num[i] == q_rt)) w_rt_hit = 1'b1;
            if (r_fifo_vld[i] && (r_fifo_num[i] == q_rd)) w_rd_hit = 1'b1;
        end
    end

    // A result arriving this cycle is already in flight, enqueued or bypassed.
    assign rs_pending = (q_rs != 5'd0) && (w_rs_hit || (w_xfer && (ll_num == q_rs)));
    assign rt_pending = (q_rt != 5'd0) && (w_rt_hit || (w_xfer && (ll_num == q_rt)));
    assign rd_pending = (q_rd != 5'd0) && (w_rd_hit || (w_xfer && (ll_num == q_rd)));

    // FIFO payload: no reset needed, occupancy is tracked by r_fifo_vld.
    // NOTE: memory arrays are left out of reset. The valid bits and pointers alone define what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_num[r_wr_ptr]  <= ll_num;
            r_fifo_data[r_wr_ptr] <= ll_data;
        end
    end

    // FIFO control. Reset discards every queued entry.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            r_fifo_vld <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fifo_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_fifo_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr             <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Register-file write port: pipe, then bypass, then FIFO head.
    // When idle, the number and data hold their last values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rd_we   <= 1'b0;
            r_rd_num  <= 5'd0;
            r_rd_data <= '0;
        end else if (w_pipe) begin
            r_rd_we   <= 1'b1;
            r_rd_num  <= p_num;
            r_rd_data <= p_data;
        end else if (w_bypass) begin
            r_rd_we   <= 1'b1;
            r_rd_num  <= ll_num;
            r_rd_data <= ll_data;
        end else if (w_pop) begin
            r_rd_we   <= 1'b1;
            r_rd_num  <= r_fifo_num[r_rd_ptr];
            r_rd_data <= r_fifo_data[r_rd_ptr];
        end else begin
            r_rd_we   <= 1'b0;
        end
    end

    // Starvation tracking. Once past the clear conditions, the FIFO is
    // non-empty and not popping, which means the pipe took the port.
    // wb_hold lags the counter by one cycle in both directions.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_starve_cnt <= '0;
            r_wb_hold    <= 1'b0;
        end else begin
            if (w_pop || w_empty) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != STARVE_LIM) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
            r_wb_hold <= (r_starve_cnt == STARVE_LIM);
        end
    end

    assign rd_we   = r_rd_we;
    assign rd_num  = r_rd_num;
    assign rd_data = r_rd_data;
    assign wb_hold = r_wb_hold;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Self-checking bench for wb_arbiter. A table of single-cycle vectors covers
// the basic pipe and FIFO behaviour. Hand-written sequences cover the
// bypass/FIFO latency, the full FIFO, starvation, and mid-stream reset.
// Inputs change 1 ns after posedge, and every output is sampled there too.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_b;
    logic            p_valid;
    logic [4:0]      p_num;
    logic [XLEN-1:0] p_data;
    logic            ll_valid;
    logic            ll_ready;
    logic [4:0]      ll_num;
    logic [XLEN-1:0] ll_data;
    logic [4:0]      q_rs, q_rt, q_rd;
    logic            rs_pending, rt_pending, rd_pending;
    logic            wb_hold;
    logic            rd_we;
    logic [4:0]      rd_num;
    logic [XLEN-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.XLEN(XLEN), .DEPTH(4), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .p_valid    (p_valid),
        .p_num      (p_num),
        .p_data     (p_data),
        .ll_valid   (ll_valid),
        .ll_ready   (ll_ready),
        .ll_num     (ll_num),
        .ll_data    (ll_data),
        .q_rs       (q_rs),
        .q_rt       (q_rt),
        .q_rd       (q_rd),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending),
        .rd_pending (rd_pending),
        .wb_hold    (wb_hold),
        .rd_we      (rd_we),
        .rd_num     (rd_num),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [4:0]  pn;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  ln;
        logic [31:0] ld;
        logic [4:0]  qs, qt, qd;
        logic        e_ready, e_rs, e_rt, e_rd;
        logic        e_we;
        logic [4:0]  e_num;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [10];

    logic [4:0]  exp_num  [$];
    logic [31:0] exp_data [$];
    logic        took;
    logic        saw_we;
    int          got;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid  = 1'b0; p_num  = '0; p_data  = '0;
        ll_valid = 1'b0; ll_num = '0; ll_data = '0;
        q_rs = '0; q_rt = '0; q_rd = '0;
    endtask

    initial begin
        // pv pn pd            lv ln ld       qs qt qd  rdy rs rt rd  we num data
        vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0, 0,  1, 0, 0, 0,  1, 5, 32'hDEADBEEF};
        vecs[1] = '{1, 0, 32'h123,      0, 0, 0,     0, 0, 0,  1, 0, 0, 0,  0, 5, 32'hDEADBEEF};
        vecs[2] = '{0, 0, 0,            0, 0, 0,     5, 0, 0,  1, 0, 0, 0,  0, 5, 32'hDEADBEEF};
        vecs[3] = '{1, 3, 32'h11,       1, 7, 32'h22, 7, 0, 0, 1, 1, 0, 0,  1, 3, 32'h11};
        vecs[4] = '{0, 0, 0,            0, 0, 0,     7, 7, 3,  1, 1, 1, 0,  1, 7, 32'h22};
        vecs[5] = '{0, 0, 0,            0, 0, 0,     7, 0, 0,  1, 0, 0, 0,  0, 7, 32'h22};
        vecs[6] = '{1, 1, 32'hA,        1, 0, 32'h99, 0, 0, 0, 1, 0, 0, 0,  1, 1, 32'hA};
        vecs[7] = '{0, 0, 0,            0, 0, 0,     0, 0, 0,  1, 0, 0, 0,  0, 1, 32'hA};
        vecs[8] = '{1, 4, 32'h44,       1, 2, 32'h33, 0, 2, 0, 1, 0, 1, 0,  1, 4, 32'h44};
        vecs[9] = '{1, 0, 32'hBAD,      0, 0, 0,     0, 2, 0,  1, 0, 1, 0,  1, 2, 32'h33};

        // ---------------- reset state ----------------
        idle();
        rst_b = 1'b0;
        #12;
        check("rst_we",    rd_we,    0);
        check("rst_num",   rd_num,   0);
        check("rst_data",  rd_data,  0);
        check("rst_hold",  wb_hold,  0);
        check("rst_ready", ll_ready, 0);
        @(negedge clk);
        rst_b = 1'b1;
        tick();

        // ---------------- table vectors ----------------
        for (int i = 0; i < 10; i++) begin
            p_valid  = vecs[i].pv; p_num  = vecs[i].pn; p_data  = vecs[i].pd;
            ll_valid = vecs[i].lv; ll_num = vecs[i].ln; ll_data = vecs[i].ld;
            q_rs = vecs[i].qs; q_rt = vecs[i].qt; q_rd = vecs[i].qd;
            #1;
            check($sformatf("v%0d_ready", i), ll_ready,   vecs[i].e_ready);
            check($sformatf("v%0d_rs", i),    rs_pending, vecs[i].e_rs);
            check($sformatf("v%0d_rt", i),    rt_pending, vecs[i].e_rt);
            check($sformatf("v%0d_rd", i),    rd_pending, vecs[i].e_rd);
            tick();
            check($sformatf("v%0d_we", i),    rd_we,   vecs[i].e_we);
            check($sformatf("v%0d_num", i),   rd_num,  vecs[i].e_num);
            check($sformatf("v%0d_data", i),  rd_data, vecs[i].e_data);
        end
        idle();
        tick();
        check("post_table_we", rd_we, 0);

        // ---------------- ll result with empty FIFO and idle pipe ----------------
        ll_valid = 1'b1; ll_num = 5'd9; ll_data = 32'h5; q_rs = 5'd9;
        #1;
        check("byp_pend_xfer", rs_pending, 1);
        tick();
        ll_valid = 1'b0; ll_num = '0; ll_data = '0;
`ifdef WB_BYPASS_EN
        check("byp_we",   rd_we,   1);
        check("byp_num",  rd_num,  9);
        check("byp_data", rd_data, 32'h5);
        #1;
        check("byp_pend_after", rs_pending, 0);
        tick();
        check("byp_fifo_empty_we", rd_we, 0);
`else
        check("fifo_lat_we_n1", rd_we, 0);
        #1;
        check("fifo_lat_pend", rs_pending, 1);
        tick();
        check("fifo_lat_we",   rd_we,   1);
        check("fifo_lat_num",  rd_num,  9);
        check("fifo_lat_data", rd_data, 32'h5);
        #1;
        check("fifo_lat_pend_after", rs_pending, 0);
        tick();
        check("fifo_lat_we_after", rd_we, 0);
`endif
        idle();

        // ---------------- full FIFO ----------------
        for (int i = 0; i < 5; i++) begin
            exp_num.push_back(5'(11 + i));
            exp_data.push_back(32'h100 + 32'(i));
        end
        for (int i = 0; i < 4; i++) begin
            p_valid = 1'b1; p_num = 5'(20 + i); p_data = 32'h200 + 32'(i);
            ll_valid = 1'b1; ll_num = 5'(11 + i); ll_data = 32'h100 + 32'(i);
            #1;
            check($sformatf("full_ready%0d", i), ll_ready, 1);
            tick();
            check($sformatf("full_pipe%0d", i), rd_num, 64'(20 + i));
        end
        p_num = 5'd24; p_data = 32'h204;
        ll_num = 5'd15; ll_data = 32'h104;
        #1;
        check("full_ready_5th", ll_ready, 0);
        tick();
        check("full_pipe_we5",  rd_we,  1);
        check("full_pipe_num5", rd_num, 24);
        p_valid = 1'b0; p_num = '0; p_data = '0;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            #1;
            if (c == 0) check("full_ready_pop_cycle", ll_ready, 0);
            took = ll_valid && ll_ready;
            tick();
            if (took) ll_valid = 1'b0;
            if (rd_we) begin
                if (exp_num.size() > 0) begin
                    check($sformatf("full_out%0d_num", got),  rd_num,  exp_num.pop_front());
                    check($sformatf("full_out%0d_data", got), rd_data, exp_data.pop_front());
                end
                got++;
            end
        end
        check("full_out_count", got, 5);
        idle();
        tick();
        check("full_drained_we", rd_we, 0);

        // ---------------- starvation ----------------
        p_valid = 1'b1; p_num = 5'd1; p_data = 32'h1000;
        ll_valid = 1'b1; ll_num = 5'd9; ll_data = 32'h5;
        tick();
        ll_valid = 1'b0; ll_num = '0; ll_data = '0;
        check("starve_hold_push", wb_hold, 0);
        for (int i = 0; i < 8; i++) begin
            p_data = 32'h1001 + 32'(i);
            tick();
            check($sformatf("starve_hold_c%0d", i + 1), wb_hold, 0);
        end
        p_data = 32'h2000;
        tick();
        check("starve_hold_c9",  wb_hold, 1);
        check("starve_pipe_num", rd_num,  1);
        check("starve_pipe_dat", rd_data, 32'h2000);
        p_valid = 1'b0; p_num = '0; p_data = '0;
        tick();
        check("starve_pop_we",   rd_we,   1);
        check("starve_pop_num",  rd_num,  9);
        check("starve_pop_data", rd_data, 32'h5);
        check("starve_pop_hold", wb_hold, 1);
        tick();
        check("starve_hold_fall", wb_hold, 0);
        check("starve_idle_we",   rd_we,   0);

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < 3; i++) begin
            p_valid = 1'b1; p_num = 5'(20 + i); p_data = 32'h300 + 32'(i);
            ll_valid = 1'b1; ll_num = 5'(11 + i); ll_data = 32'h400 + 32'(i);
            tick();
        end
        #2;
        rst_b = 1'b0;
        #1;
        check("mid_rst_we",    rd_we,    0);
        check("mid_rst_ready", ll_ready, 0);
        check("mid_rst_num",   rd_num,   0);
        idle();
        tick();
        tick();
        @(negedge clk);
        rst_b = 1'b1;
        q_rs = 5'd11; q_rt = 5'd12; q_rd = 5'd13;
        tick();
        check("post_rst_ready", ll_ready,   1);
        check("post_rst_rs",    rs_pending, 0);
        check("post_rst_rt",    rt_pending, 0);
        check("post_rst_rd",    rd_pending, 0);
        saw_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rd_we) saw_we = 1'b1;
        end
        check("post_rst_no_ghost", saw_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
